// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle ops, bit-serial shift-add MUL and restoring DIV.
// Define ALU_DIV_EN to build the divider; otherwise opcode B acts as reserved.
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic             ALU_clk,
  input  logic             ALU_rst_n,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [3:0]       Op,
  input  logic             Start,
  output logic [WIDTH-1:0] Acc_in,
  output logic [WIDTH-1:0] Res_hi,
  output logic             Acc_we,
  output logic             Busy,
  output logic             Z_flag,
  output logic             C_flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_DEC  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIV  = 4'hB;
  localparam logic [3:0] OP_PASS = 4'hC;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rhi_q, rhi_d;
  logic             z_q, z_d;
  logic             c_q, c_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_c;
  logic [WIDTH:0]   ext;
  logic             go_exec;
  logic [WIDTH-1:0] fin_acc, fin_hi;
  logic             fin_c;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   div_shl, div_trial;
  logic [WIDTH-1:0] div_rem, div_quo;
`endif

  // One shift-add step: conditionally add A to the high half, then shift right.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  // One restoring step: shift next dividend bit into the remainder, trial-subtract.
  always_comb begin
    div_shl   = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shl - {1'b0, b_q};
    if (!div_trial[WIDTH]) begin
      div_rem = div_trial[WIDTH-1:0];
      div_quo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem = div_shl[WIDTH-1:0];
      div_quo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end
`endif

  always_comb begin
    alu_res = A_in;
    alu_hi  = '0;
    alu_c   = 1'b0;
    ext     = '0;
    case (Op)
      OP_ADD: begin
        ext     = {1'b0, A_in} + {1'b0, B_in};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      OP_SUB: begin
        ext     = {1'b0, A_in} - {1'b0, B_in};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      OP_AND: alu_res = A_in & B_in;
      OP_OR:  alu_res = A_in | B_in;
      OP_XOR: alu_res = A_in ^ B_in;
      OP_NOT: alu_res = ~A_in;
      OP_INC: begin
        ext     = {1'b0, A_in} + (WIDTH+1)'(1);
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      OP_DEC: begin
        ext     = {1'b0, A_in} - (WIDTH+1)'(1);
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      OP_SHL: begin
        alu_res = {A_in[WIDTH-2:0], 1'b0};
        alu_c   = A_in[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, A_in[WIDTH-1:1]};
        alu_c   = A_in[0];
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        alu_res = '1;
        alu_hi  = A_in;
        alu_c   = 1'b1;
      end
`endif
      OP_PASS: alu_res = B_in;
      default: alu_res = A_in;
    endcase
  end

  always_comb begin
    go_exec = (Op == OP_MUL);
`ifdef ALU_DIV_EN
    go_exec = go_exec || ((Op == OP_DIV) && (B_in != '0));
`endif
  end

  always_comb begin
    fin_acc = mul_lo;
    fin_hi  = mul_hi;
    fin_c   = (mul_hi != '0);
`ifdef ALU_DIV_EN
    if (op_q == OP_DIV) begin
      fin_acc = div_quo;
      fin_hi  = div_rem;
      fin_c   = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    rhi_d   = rhi_q;
    z_d     = z_q;
    c_d     = c_q;
`ifdef ALU_DIV_EN
    b_d     = b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d  = Op;
          a_d   = A_in;
          cnt_d = '0;
`ifdef ALU_DIV_EN
          b_d   = B_in;
`endif
          if (go_exec) begin
            state_d = S_EXEC;
            hi_d    = '0;
            lo_d    = (Op == OP_MUL) ? B_in : A_in;
          end else begin
            state_d = S_DONE;
            acc_d   = alu_res;
            rhi_d   = alu_hi;
            c_d     = alu_c;
            z_d     = (alu_res == '0);
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + CW'(1);
        hi_d  = mul_hi;
        lo_d  = mul_lo;
`ifdef ALU_DIV_EN
        if (op_q == OP_DIV) begin
          hi_d = div_rem;
          lo_d = div_quo;
        end
`endif
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          acc_d   = fin_acc;
          rhi_d   = fin_hi;
          c_d     = fin_c;
          z_d     = (fin_acc == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ALU_clk or negedge ALU_rst_n) begin
    if (!ALU_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      rhi_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
`ifdef ALU_DIV_EN
      b_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      rhi_q   <= rhi_d;
      z_q     <= z_d;
      c_q     <= c_d;
`ifdef ALU_DIV_EN
      b_q     <= b_d;
`endif
    end
  end

  assign Acc_in = acc_q;
  assign Res_hi = rhi_q;
  assign Z_flag = z_q;
  assign C_flag = c_q;
  assign Acc_we = (state_q == S_DONE);
  assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed cases then random ops
// against an arithmetic reference model.
module tb_alu_seq_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_in, b_in;
  logic [3:0]   op;
  logic         start;
  logic [W-1:0] acc, rhi;
  logic         we, busy, zf, cf;

  alu_seq_unit #(.WIDTH(W)) dut (
    .ALU_clk  (clk),
    .ALU_rst_n(rst_n),
    .A_in     (a_in),
    .B_in     (b_in),
    .Op       (op),
    .Start    (start),
    .Acc_in   (acc),
    .Res_hi   (rhi),
    .Acc_we   (we),
    .Busy     (busy),
    .Z_flag   (zf),
    .C_flag   (cf)
  );

  typedef struct {
    int acc;
    int hi;
    int z;
    int c;
    int cyc;
    int busy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   busy_run = 0;
  bit   chk_idle = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the latched operands.
  function automatic exp_t model(input int o, input int a, input int b,
                                 input int c0);
    exp_t r;
    int   s;
    bit   multi;
    multi = 0;
    r.hi  = 0;
    r.c   = 0;
    r.acc = a;
    case (o)
      0: begin s = a + b; r.acc = s % 256; r.c = (s > 255); end
      1: begin r.acc = (a - b + 256) % 256; r.c = (a < b); end
      2: r.acc = a & b;
      3: r.acc = a | b;
      4: r.acc = a ^ b;
      5: r.acc = 255 - a;
      6: begin r.acc = (a + 1) % 256; r.c = (a == 255); end
      7: begin r.acc = (a + 255) % 256; r.c = (a == 0); end
      8: begin r.acc = (a * 2) % 256; r.c = (a >= 128); end
      9: begin r.acc = a / 2; r.c = a % 2; end
      10: begin
        s = a * b;
        r.acc = s % 256;
        r.hi  = s / 256;
        r.c   = (r.hi != 0);
        multi = 1;
      end
`ifdef ALU_DIV_EN
      11: begin
        if (b == 0) begin
          r.acc = 255; r.hi = a; r.c = 1;
        end else begin
          r.acc = a / b; r.hi = a % b; multi = 1;
        end
      end
`endif
      12: r.acc = b;
      default: r.acc = a;
    endcase
    r.z    = (r.acc == 0);
    r.cyc  = c0 + (multi ? W : 0);
    r.busy = multi ? W + 1 : 1;
    return r;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
  endtask

  task automatic issue(input int o, input int a, input int b);
    wait_idle();
    op    = 4'(o);
    a_in  = 8'(a);
    b_in  = 8'(b);
    start = 1'b1;
    q.push_back(model(o, a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        chk("busy_after_we", int'(busy), 0);
        chk_idle = 0;
      end
      if (busy) busy_run++;
      else busy_run = 0;
      if (we) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_we: Acc_we=1 expected 0 (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("acc", int'(acc), e.acc);
          chk("res_hi", int'(rhi), e.hi);
          chk("z_flag", int'(zf), e.z);
          chk("c_flag", int'(cf), e.c);
          chk("we_cycle", cyc, e.cyc);
          chk("busy_len", busy_run, e.busy);
          chk_idle = 1;
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    a_in  = '0;
    b_in  = '0;
    #12;
    chk("rst_acc", int'(acc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_z", int'(zf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 8'h49, 8'h06);
    issue(0, 8'hFF, 8'h01);
    issue(1, 8'h05, 8'h06);
    issue(9, 8'h81, 8'h00);
    issue(14, 8'h00, 8'h5A);
    issue(11, 8'h49, 8'h06);
    issue(11, 8'h49, 8'h00);

    // MUL with Start held during the iterations: those starts must be dropped.
    issue(10, 8'h49, 8'h06);
    repeat (6) begin
      op    = 4'h0;
      a_in  = 8'h11;
      b_in  = 8'h22;
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;

    // Asynchronous reset in the middle of a long multiply.
    issue(10, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_acc", int'(acc), 0);
    chk("midrst_hi", int'(rhi), 0);
    chk("midrst_we", int'(we), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_z", int'(zf), 0);
    chk("midrst_c", int'(cf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(6, 8'hFF, 8'h00);

    for (int i = 0; i < 300; i++) begin
      int o, a, b;
      o = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) a = 255;
      issue(o, a, b);
    end

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
